// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory responder: FSM encoding,
// bus widths, the MMIO display address and the half-word merge helper.
package mem_bus_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] DISPLAY_ADDR = 10'h3FF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   // A half write keeps the stored upper 16 bits and replaces the lower 16.
   function automatic logic [DATA_W-1:0] merge_half(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic              half);
      return half ? {old_word[31:16], new_word[15:0]} : new_word;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/ack bus between an initiator (master) and the memory responder (slave).
interface mem_responder_if;
   import mem_bus_pkg::*;

   // Handshake: the master raises req with we/half/addr/wdata stable and holds
   // them until it sees ack; ack is a one-cycle pulse, rdata is meaningful only
   // while ack=1 on a read and is 0 otherwise. Dropping req before ack aborts.
   logic              req;
   logic              we;
   logic              half;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   modport master (
      output req, we, half, addr, wdata,
      input  ack, rdata, busy
   );

   modport slave (
      input  req, we, half, addr, wdata,
      output ack, rdata, busy
   );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port word array: registered read of addr every cycle,
// write on the same edge when we is high. Contents are never reset.
module mem_array
   import mem_bus_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE/WAIT/ACK FSM, wait counter, display MMIO
// decode and out-of-range handling in front of a synchronous word array.
module mem_responder
   import mem_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH       = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_responder_if.slave    bus,
   output logic [DATA_W-1:0] display,
   output state_t            fsm_state
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state, state_next;
   logic [3:0]        cnt, cnt_next;
   logic [1:0]        rst_sync;
   logic              rst_int;
   logic              is_display;
   logic              in_range;
   logic              commit;
   logic              arr_we;
   logic [DATA_W-1:0] arr_rdata;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] read_data;

   // Reset asserts immediately but releases two edges later, so the first
   // request after release is sampled no earlier than the third edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int = rst_sync[1];

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (bus.req) begin
               if (WAIT_CYCLES == 0) begin
                  state_next = ST_ACK;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            // Abort takes priority over the counter reaching zero.
            if (!bus.req) begin
               state_next = ST_IDLE;
               cnt_next   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_next = ST_ACK;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   assign is_display = (bus.addr == DISPLAY_ADDR);
   assign in_range   = !is_display && (32'(bus.addr) < DEPTH);
   assign commit     = (state == ST_ACK) && bus.we;
   assign arr_we     = commit && in_range;

   // The array read port tracks addr every cycle, so the old word is already
   // on arr_rdata during ACK and a half write can merge against it.
   assign arr_wdata = merge_half(arr_rdata, bus.wdata, bus.half);

   mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (bus.addr[IDX_W-1:0]),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         display <= '0;
      end else if (commit && is_display) begin
         display <= merge_half(display, bus.wdata, bus.half);
      end
   end

   always_comb begin
      read_data = '0;
      if (is_display) begin
         read_data = display;
      end else if (in_range) begin
         read_data = arr_rdata;
      end
   end

   assign bus.ack   = (state == ST_ACK);
   assign bus.busy  = (state != ST_IDLE);
   assign bus.rdata = ((state == ST_ACK) && !bus.we) ? read_data : '0;
   assign fsm_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 / DEPTH=512 instance for
// function, MMIO, abort and reset, and a WAIT_CYCLES=0 instance for throughput.
module tb_mem_responder;
   import mem_bus_pkg::*;

   logic clk;
   logic rst_n;

   mem_responder_if bus2 ();
   mem_responder_if bus0 ();

   logic [31:0] display2, display0;
   state_t      state2, state0;

   mem_responder #(.WAIT_CYCLES(2), .DEPTH(512)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus2.slave),
      .display   (display2),
      .fsm_state (state2)
   );

   mem_responder #(.WAIT_CYCLES(0), .DEPTH(1024)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus0.slave),
      .display   (display0),
      .fsm_state (state0)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q2[$];
   logic [31:0] exp_q0[$];
   logic [31:0] e2, e0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (bus2.ack === 1'b1) begin
         if (exp_q2.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ack2_unexpected: got ack with rdata 0x%08h, required no ack", bus2.rdata);
         end else begin
            e2 = exp_q2.pop_front();
            check("rdata2", bus2.rdata, e2);
         end
      end
   end

   always @(negedge clk) begin
      if (bus0.ack === 1'b1) begin
         if (exp_q0.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ack0_unexpected: got ack with rdata 0x%08h, required no ack", bus0.rdata);
         end else begin
            e0 = exp_q0.pop_front();
            check("rdata0", bus0.rdata, e0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One complete access on the WAIT_CYCLES=2 instance. req is raised just after
   // an edge; the next edge samples it, two WAIT cycles follow, so ack is seen
   // after the third edge counted from raising req.
   task automatic do_access2(input logic w, input logic h, input logic [9:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd);
      int lat;
      bit got;
      exp_q2.push_back(w ? 32'h0 : exp_rd);
      @(posedge clk); #1;
      bus2.we = w; bus2.half = h; bus2.addr = a; bus2.wdata = d; bus2.req = 1'b1;
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (bus2.ack === 1'b1) begin
            got = 1'b1;
            lat = k;
            break;
         end
      end
      if (got) begin
         check("latency2", 32'(lat), 32'd3);
      end else begin
         tests++;
         fails++;
         $display("FAIL ack2_timeout: got no ack in 12 cycles, required ack at cycle 3");
      end
      bus2.req = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.half = 1'b0; bus2.addr = '0; bus2.wdata = '0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.half = 1'b0; bus0.addr = '0; bus0.wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(bus2.ack), 32'd0);
      check("rst_busy", 32'(bus2.busy), 32'd0);
      check("rst_rdata", bus2.rdata, 32'h0);
      check("rst_display", display2, 32'h0);
      check("rst_state", 32'(state2), 32'(ST_IDLE));
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Basic write then read
      do_access2(1'b1, 1'b0, 10'h004, 32'hDEADBEEF, 32'h0);
      do_access2(1'b0, 1'b0, 10'h004, 32'h0, 32'hDEADBEEF);

      // Half write merges with stored upper half
      do_access2(1'b1, 1'b0, 10'h010, 32'h11112222, 32'h0);
      do_access2(1'b1, 1'b1, 10'h010, 32'hAAAA5555, 32'h0);
      do_access2(1'b0, 1'b0, 10'h010, 32'h0, 32'h11115555);

      // Half flag is ignored on a read
      do_access2(1'b0, 1'b1, 10'h004, 32'hFFFFFFFF, 32'hDEADBEEF);

      // Display MMIO; 0x1FF is the array word 0x3FF would alias onto at DEPTH=512
      do_access2(1'b1, 1'b0, 10'h1FF, 32'h5A5A5A5A, 32'h0);
      do_access2(1'b1, 1'b0, 10'h3FF, 32'h0000000A, 32'h0);
      check("display_write", display2, 32'h0000000A);
      do_access2(1'b0, 1'b0, 10'h3FF, 32'h0, 32'h0000000A);
      do_access2(1'b0, 1'b0, 10'h1FF, 32'h0, 32'h5A5A5A5A);
      do_access2(1'b1, 1'b1, 10'h3FF, 32'hFFFF00B0, 32'h0);
      check("display_half", display2, 32'h000000B0);

      // Out-of-range: write ignored, read returns 0, aliased word untouched
      do_access2(1'b1, 1'b0, 10'h000, 32'h13579BDF, 32'h0);
      do_access2(1'b1, 1'b0, 10'h200, 32'h77777777, 32'h0);
      do_access2(1'b0, 1'b0, 10'h200, 32'h0, 32'h0);
      do_access2(1'b0, 1'b0, 10'h000, 32'h0, 32'h13579BDF);

      // Abort: drop req after one WAIT cycle
      do_access2(1'b1, 1'b0, 10'h020, 32'hCAFEF00D, 32'h0);
      @(posedge clk); #1;
      bus2.we = 1'b1; bus2.half = 1'b0; bus2.addr = 10'h020; bus2.wdata = 32'h12345678; bus2.req = 1'b1;
      @(posedge clk); #1;
      check("abort_busy_wait", 32'(bus2.busy), 32'd1);
      check("abort_state_wait", 32'(state2), 32'(ST_WAIT));
      @(posedge clk); #1;
      bus2.req = 1'b0;
      @(posedge clk); #1;
      check("abort_busy_low", 32'(bus2.busy), 32'd0);
      check("abort_ack_low", 32'(bus2.ack), 32'd0);
      repeat (3) @(posedge clk);
      do_access2(1'b0, 1'b0, 10'h020, 32'h0, 32'hCAFEF00D);

      // Reset during WAIT of a write
      @(posedge clk); #1;
      bus2.we = 1'b1; bus2.half = 1'b0; bus2.addr = 10'h020; bus2.wdata = 32'h99999999; bus2.req = 1'b1;
      @(posedge clk); #1;
      check("rstmid_busy_before", 32'(bus2.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_ack", 32'(bus2.ack), 32'd0);
      check("rstmid_busy", 32'(bus2.busy), 32'd0);
      check("rstmid_display", display2, 32'h0);
      check("rstmid_state", 32'(state2), 32'(ST_IDLE));
      bus2.we = 1'b0;
      @(posedge clk); #1;
      // Release with a read already pending: not accepted on the first edge
      exp_q2.push_back(32'hCAFEF00D);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rstrel_first_edge_busy", 32'(bus2.busy), 32'd0);
      begin
         bit got;
         got = 1'b0;
         for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus2.ack === 1'b1) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            tests++;
            fails++;
            $display("FAIL rstrel_ack_timeout: got no ack in 12 cycles, required ack");
         end
      end
      bus2.req = 1'b0;
      @(posedge clk); #1;

      // WAIT_CYCLES=0: one write, then back-to-back reads with req held high
      exp_q0.push_back(32'h0);
      bus0.we = 1'b1; bus0.half = 1'b0; bus0.addr = 10'h030; bus0.wdata = 32'h0BADF00D; bus0.req = 1'b1;
      @(posedge clk); #1;
      check("w0_write_ack", 32'(bus0.ack), 32'd1);
      @(posedge clk); #1;
      bus0.we = 1'b0;
      repeat (3) exp_q0.push_back(32'h0BADF00D);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         check("w0_ack_toggle", 32'(bus0.ack), 32'(i % 2));
         check("w0_busy_toggle", 32'(bus0.busy), 32'(i % 2));
      end
      bus0.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // ---------------- final report ----------------
      check("exp_q2_drained", 32'(exp_q2.size()), 32'd0);
      check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
